// File: rtl/div6_seq.sv
// ============================================================================
// Module   : div6_seq (with cla6_bit)
// Brief    : 6-bit unsigned restoring divider, one quotient bit per clock
//            through a shared carry-lookahead adder used as a subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// 6-bit carry-lookahead adder: every carry is a flat sum of generate/propagate
// products, so no carry ripples through earlier stages.
module cla6_bit (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       c0,
    output logic [5:0] s,
    output logic       c_out
);
    logic [5:0] w_p;
    logic [5:0] w_g;
    logic [6:0] w_c;
    logic       w_term;
    logic       w_prop;

    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_c    = '0;
        w_term = 1'b0;
        w_prop = 1'b0;
        w_c[0] = c0;
        for (int i = 0; i < 6; i++) begin
            w_term = c0;
            for (int j = 0; j <= i; j++) begin
                w_term = w_term & w_p[j];
            end
            w_c[i+1] = w_term;
            for (int j = 0; j <= i; j++) begin
                w_prop = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_prop = w_prop & w_p[k];
                end
                w_c[i+1] = w_c[i+1] | w_prop;
            end
        end
        s     = w_p ^ w_c[5:0];
        c_out = w_c[6];
    end
endmodule

module div6_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] dividend,
    input  logic [5:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [5:0] quotient,
    output logic [5:0] remainder,
    output logic       div_by_zero
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_p;
    logic [5:0] r_q;
    logic [5:0] r_dl;
    logic [2:0] r_cnt;
    logic [5:0] w_t;
    logic [5:0] w_diff;
    logic       w_ge;
    logic [5:0] w_p_next;
    logic [5:0] w_q_next;
    logic       w_accept;

    // T = {P[4:0], Q[5]} fits in 6 bits because P < 2^(k-1) before step k.
    assign w_t = {r_p[4:0], r_q[5]};

    cla6_bit u_sub (
        .a     (w_t),
        .b     (~r_dl),
        .c0    (1'b1),
        .s     (w_diff),
        .c_out (w_ge)
    );

    assign w_p_next = w_ge ? w_diff : w_t;
    assign w_q_next = {r_q[4:0], w_ge};
    assign w_accept = start && (r_state != S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = (divisor == 6'd0) ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == 3'd5) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p         <= '0;
            r_q         <= '0;
            r_dl        <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            if (divisor != 6'd0) begin
                r_p         <= '0;
                r_q         <= dividend;
                r_dl        <= divisor;
                r_cnt       <= '0;
                div_by_zero <= 1'b0;
            end else begin
                quotient    <= 6'h3F;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_p   <= w_p_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd5) begin
                quotient  <= w_q_next;
                remainder <= w_p_next;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
endmodule

`default_nettype wire

// File: tb/tb_div6_seq.sv
// ============================================================================
// Module   : tb_div6_seq
// Brief    : Scoreboard bench for div6_seq with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div6_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] dividend = '0;
    logic [5:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       div_by_zero;

    div6_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       acc_edge;
        logic [5:0] q;
        logic [5:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   free_edge = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: an operation occupies the divider for 7 edges (1 for
    // D=0); a start is taken on the first edge where it is free again.
    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            free_edge = cyc + 1;
        end else if (start && cyc >= free_edge) begin
            e.acc_edge = cyc;
            if (divisor == 0) begin
                e.q = 6'h3F; e.r = dividend; e.dz = 1'b1;
                free_edge = cyc + 1;
            end else begin
                e.q = 6'(int'(dividend) / int'(divisor));
                e.r = 6'(int'(dividend) % int'(divisor));
                e.dz = 1'b0;
                free_edge = cyc + 7;
            end
            sb.push_back(e);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        exp_busy = 1'b0;
        if (sb.size() > 0 && !sb[0].dz && cyc >= sb[0].acc_edge + 1 && cyc <= sb[0].acc_edge + 6)
            exp_busy = 1'b1;
        if (!reset) begin
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            end
        end
        if (done) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done cyc=%0d got done=1 want done=0", cyc);
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz ||
                    cyc != e.acc_edge + (e.dz ? 1 : 7)) begin
                    miscompares++;
                    $display("FAIL result cyc=%0d got q=%0d r=%0d dz=%b lat=%0d want q=%0d r=%0d dz=%b lat=%0d",
                             cyc, quotient, remainder, div_by_zero, cyc - e.acc_edge,
                             e.q, e.r, e.dz, e.dz ? 1 : 7);
                end
            end
        end else if (sb.size() > 0 && cyc >= sb[0].acc_edge + (sb[0].dz ? 1 : 7)) begin
            e = sb.pop_front();
            miscompares++;
            $display("FAIL missing_done cyc=%0d got done=0 want done=1", cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout got pending=%0d want pending=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [5:0] n, input logic [5:0] d);
        start = 1'b1; dividend = n; divisor = d;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wait_drain();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        chk("reset_dz", div_by_zero, 0);

        run_op(45, 7);
        chk("q_45_7", quotient, 6);
        chk("r_45_7", remainder, 3);
        run_op(63, 1);  chk("q_63_1", quotient, 63);
        run_op(5, 9);   chk("r_5_9", remainder, 5);
        run_op(63, 63); chk("q_63_63", quotient, 1);
        run_op(62, 63); chk("r_62_63", remainder, 62);
        run_op(40, 0);
        chk("q_40_0", quotient, 63);
        chk("dz_40_0", div_by_zero, 1);
        run_op(40, 8);
        chk("q_40_8", quotient, 5);
        chk("dz_cleared", div_by_zero, 0);

        // start held high; operands change mid-run
        start = 1'b1; dividend = 45; divisor = 7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 1) begin dividend = 6'($urandom); divisor = 6'($urandom_range(1, 63)); end
            if (i == 5) begin dividend = 45; divisor = 7; end
        end
        start = 1'b0;
        wait_drain();

        // reset during RUN aborts the operation
        start = 1'b1; dividend = 50; divisor = 3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        repeat (8) @(negedge clk);
        run_op(50, 3);
        chk("after_abort_q", quotient, 16);

        // randomized start/operand stream
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) != 0);
            dividend = 6'($urandom);
            divisor = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_drain();

        for (int n = 0; n < 64; n++) begin
            for (int d = 0; d < 64; d++) begin
                run_op(6'(n), 6'(d));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
